game_flow_fsm: RTL and testbench

//   Parametrised top-level game-flow controller for the runner game. Sequences

---
 rtl/game_flow_if.sv | 27 ++
 rtl/game_flow_fsm.sv | 118 +++++++++++
 tb/tb_game_flow_fsm.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/game_flow_if.sv
// Handshake/status bundle between the game-flow controller and its neighbours
// (debouncers and collision detector in, render/obstacle logic out).
interface game_flow_if #(
   parameter int LIFE_W  = 2,
   parameter int SCORE_W = 16
);
   logic               tick;
   logic               jump;
   logic               pause;
   logic               collided;
   logic [2:0]         state;
   logic [LIFE_W-1:0]  lives;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] hi_score;
   logic               run_en;
   logic               new_record;

   modport master (
      output tick, jump, pause, collided,
      input  state, lives, score, hi_score, run_en, new_record
   );

   modport slave (
      input  tick, jump, pause, collided,
      output state, lives, score, hi_score, run_en, new_record
   );
endinterface

// File: rtl/game_flow_fsm.sv
// Runner game flow controller: INIT -> READY countdown -> RUN, with PAUSE,
// multi-life HIT freeze, DEAD restart lockout, score and high-score tracking.
module game_flow_fsm #(
   parameter int LIVES        = 3,
   parameter int LIFE_W       = 2,
   parameter int SCORE_W      = 16,
   parameter int START_DELAY  = 16,
   parameter int HIT_FREEZE   = 32,
   parameter int RESTART_LOCK = 8,
   parameter int TMR_W        = 8
) (
   input  logic        clk,
   input  logic        rst,
   game_flow_if.slave  bus
);
   localparam logic [2:0] S_INIT  = 3'b000;
   localparam logic [2:0] S_READY = 3'b001;
   localparam logic [2:0] S_RUN   = 3'b010;
   localparam logic [2:0] S_PAUSE = 3'b011;
   localparam logic [2:0] S_HIT   = 3'b100;
   localparam logic [2:0] S_DEAD  = 3'b101;

   localparam logic [TMR_W-1:0]   T_START = TMR_W'(START_DELAY);
   localparam logic [TMR_W-1:0]   T_HIT   = TMR_W'(HIT_FREEZE);
   localparam logic [TMR_W-1:0]   T_LOCK  = TMR_W'(RESTART_LOCK);
   localparam logic [TMR_W-1:0]   T_ONE   = TMR_W'(1);
   localparam logic [LIFE_W-1:0]  L_FULL  = LIFE_W'(LIVES);
   localparam logic [LIFE_W-1:0]  L_ONE   = LIFE_W'(1);

   logic [2:0]         state;
   logic [TMR_W-1:0]   timer;
   logic [LIFE_W-1:0]  lives;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] hi_score;
   logic               new_record;
   logic               jump_q;
   logic               pause_q;
   logic               jr;
   logic               pr;

   assign jr = bus.jump  & ~jump_q;
   assign pr = bus.pause & ~pause_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_INIT;
         timer      <= '0;
         lives      <= L_FULL;
         score      <= '0;
         hi_score   <= '0;
         new_record <= 1'b0;
         jump_q     <= 1'b0;
         pause_q    <= 1'b0;
      end else begin
         jump_q     <= bus.jump;
         pause_q    <= bus.pause;
         new_record <= 1'b0;
         case (state)
            S_INIT: begin
               if (jr) begin
                  state <= S_READY;
                  timer <= T_START;
                  lives <= L_FULL;
                  score <= '0;
               end
            end
            S_READY, S_HIT: begin
               // Countdown ends on the tick that sees timer==1.
               if (bus.tick) begin
                  if (timer == T_ONE) state <= S_RUN;
                  else                timer <= timer - T_ONE;
               end
            end
            S_RUN: begin
               if (bus.collided) begin
                  if (lives <= L_ONE) begin
                     state <= S_DEAD;
                     lives <= '0;
                     timer <= T_LOCK;
                     if (score > hi_score) begin
                        hi_score   <= score;
                        new_record <= 1'b1;
                     end
                  end else begin
                     state <= S_HIT;
                     lives <= lives - L_ONE;
                     timer <= T_HIT;
                  end
               end else if (pr) begin
                  state <= S_PAUSE;
               end else if (bus.tick && score != {SCORE_W{1'b1}}) begin
                  score <= score + 1'b1;
               end
            end
            S_PAUSE: begin
               if (pr) state <= S_RUN;
            end
            S_DEAD: begin
               // Lock is tested on the registered timer, so a jr alongside
               // the zeroing tick is still locked out.
               if (timer == '0) begin
                  if (jr) state <= S_INIT;
               end else if (bus.tick) begin
                  timer <= timer - T_ONE;
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

   assign bus.state      = state;
   assign bus.lives      = lives;
   assign bus.score      = score;
   assign bus.hi_score   = hi_score;
   assign bus.run_en     = (state == S_RUN);
   assign bus.new_record = new_record;
endmodule

// File: tb/tb_game_flow_fsm.sv
// Directed bench for game_flow_fsm: full default-parameter game flow plus a
// narrow-score instance for saturation and asynchronous mid-game reset.
module tb_game_flow_fsm;
   logic clk;
   logic rst;
   int   nchk = 0;
   int   nerr = 0;

   game_flow_if #(.LIFE_W(2), .SCORE_W(16)) a ();
   game_flow_if #(.LIFE_W(2), .SCORE_W(4))  b ();

   game_flow_fsm #(
      .LIVES(3), .LIFE_W(2), .SCORE_W(16), .START_DELAY(16),
      .HIT_FREEZE(32), .RESTART_LOCK(8), .TMR_W(8)
   ) u_a (.clk(clk), .rst(rst), .bus(a));

   game_flow_fsm #(
      .LIVES(1), .LIFE_W(2), .SCORE_W(4), .START_DELAY(1),
      .HIT_FREEZE(1), .RESTART_LOCK(1), .TMR_W(8)
   ) u_b (.clk(clk), .rst(rst), .bus(b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clk on instance a: inputs applied at a negedge, outputs valid at the next.
   task automatic cyc(input logic t, input logic j, input logic p, input logic c);
      a.tick = t; a.jump = j; a.pause = p; a.collided = c;
      @(negedge clk);
   endtask

   initial begin
      a.tick = 0; a.jump = 0; a.pause = 0; a.collided = 0;
      b.tick = 0; b.jump = 0; b.pause = 0; b.collided = 0;
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_state", a.state, 3'b000);
      chk("rst_lives", a.lives, 2'd3);
      chk("rst_score", a.score, 16'd0);
      chk("rst_hi", a.hi_score, 16'd0);
      chk("rst_run_en", a.run_en, 1'b0);
      chk("rst_newrec", a.new_record, 1'b0);
      rst = 1'b1;
      cyc(0, 0, 0, 0);

      // Start: jump rise, then 16-tick READY countdown
      cyc(0, 1, 0, 0);
      chk("t1_ready", a.state, 3'b001);
      for (int i = 0; i < 15; i++) cyc(1, 1, 0, 0);
      chk("t1_ready15", a.state, 3'b001);
      cyc(1, 1, 0, 0);
      chk("t1_run16", a.state, 3'b010);
      chk("t1_run_en", a.run_en, 1'b1);
      chk("t1_lives", a.lives, 2'd3);
      chk("t1_score", a.score, 16'd0);
      cyc(0, 0, 0, 0);

      // 5 ticks, then collided for 40 clks with 10 ticks
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
      chk("t2_score5", a.score, 16'd5);
      for (int i = 0; i < 40; i++) begin
         cyc(i % 4 == 0, 0, 0, 1);
         if (i == 0) begin
            chk("t2_hit", a.state, 3'b100);
            chk("t2_run_en0", a.run_en, 1'b0);
         end
      end
      chk("t2_hit_hold", a.state, 3'b100);
      chk("t2_lives2", a.lives, 2'd2);
      chk("t2_score_hold", a.score, 16'd5);
      for (int i = 0; i < 22; i++) cyc(1, 0, 0, 0);
      chk("t2_hit31", a.state, 3'b100);
      cyc(1, 0, 0, 0);
      chk("t2_run32", a.state, 3'b010);
      chk("t2_score_keep", a.score, 16'd5);

      // Pause: ticks and collision ignored, resume same score/lives
      cyc(0, 0, 1, 0);
      chk("t5_pause", a.state, 3'b011);
      for (int i = 0; i < 20; i++) cyc(1, 0, 1, 0);
      chk("t5_pause_score", a.score, 16'd5);
      cyc(0, 0, 1, 1);
      chk("t5_pause_coll", a.state, 3'b011);
      chk("t5_pause_lives", a.lives, 2'd2);
      cyc(0, 0, 0, 0);
      chk("t5_still_pause", a.state, 3'b011);
      cyc(0, 0, 1, 0);
      chk("t5_resume", a.state, 3'b010);
      chk("t5_resume_score", a.score, 16'd5);
      chk("t5_resume_lives", a.lives, 2'd2);
      cyc(0, 0, 0, 0);

      // Second hit, recover, score to 8
      cyc(1, 0, 0, 0);
      chk("t3_score6", a.score, 16'd6);
      cyc(1, 0, 0, 1);
      chk("t3_hit2", a.state, 3'b100);
      chk("t3_lives1", a.lives, 2'd1);
      for (int i = 0; i < 32; i++) cyc(1, 0, 0, 0);
      chk("t3_run", a.state, 3'b010);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("t3_score8", a.score, 16'd8);

      // Fatal hit with tick and pause rise in the same clk
      cyc(1, 0, 1, 1);
      chk("t3_dead", a.state, 3'b101);
      chk("t3_lives0", a.lives, 2'd0);
      chk("t3_score_dead", a.score, 16'd8);
      chk("t3_newrec", a.new_record, 1'b1);
      chk("t3_hi8", a.hi_score, 16'd8);
      cyc(0, 0, 0, 0);
      chk("t3_newrec_pulse", a.new_record, 1'b0);

      // Restart lockout
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      chk("t4_lock_jump", a.state, 3'b101);
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      chk("t4_jump_on_zero", a.state, 3'b101);
      cyc(0, 0, 0, 0);
      chk("t4_no_rise", a.state, 3'b101);
      cyc(0, 1, 0, 0);
      chk("t4_init", a.state, 3'b000);
      chk("t4_init_score", a.score, 16'd8);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      chk("t4_ready2", a.state, 3'b001);
      chk("t4_score_clr", a.score, 16'd0);
      chk("t4_lives_rld", a.lives, 2'd3);
      cyc(0, 0, 0, 0);

      // Second game with a lower score
      for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0);
      chk("t4_run2", a.state, 3'b010);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         cyc(0, 0, 0, 1);
         cyc(0, 0, 0, 0);
         for (int i = 0; i < 32; i++) cyc(1, 0, 0, 0);
      end
      chk("t4_run_l1", a.state, 3'b010);
      cyc(0, 0, 0, 1);
      chk("t4_dead2", a.state, 3'b101);
      chk("t4_score3", a.score, 16'd3);
      chk("t4_hi_keep", a.hi_score, 16'd8);
      chk("t4_no_newrec", a.new_record, 1'b0);
      cyc(0, 0, 0, 0);

      // Narrow instance: saturation, then async reset mid-RUN
      b.jump = 1; @(negedge clk);
      chk("t6_ready", b.state, 3'b001);
      b.jump = 0; b.tick = 1; @(negedge clk);
      chk("t6_run", b.state, 3'b010);
      repeat (20) @(negedge clk);
      b.tick = 0;
      chk("t6_sat", b.score, 4'hF);
      chk("t6_sat_run", b.state, 3'b010);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_state", b.state, 3'b000);
      chk("t6_rst_score", b.score, 4'h0);
      chk("t6_rst_lives", b.lives, 2'd1);
      chk("t6_rst_run_en", b.run_en, 1'b0);
      chk("t6_rst_a_hi", a.hi_score, 16'd0);
      chk("t6_rst_a_lives", a.lives, 2'd3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_post_rst", a.state, 3'b000);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
